// File: rtl/pipe_wait_ctrl_pkg.sv
// pipe_pkg: shared types for the pipeline stall/flush sequencer.
//   state_t  - sequencer FSM states
//   ctrl_t   - packed bundle of the five stage enables and three flushes
//   DIV_CYCLES_DEFAULT - default divider occupancy in cycles
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  localparam int unsigned DIV_CYCLES_DEFAULT = 32;

  typedef struct packed {
    logic en_f;
    logic en_d;
    logic en_e;
    logic en_m;
    logic en_w;
    logic flush_d;
    logic flush_e;
    logic flush_m;
  } ctrl_t;

  // Common enable/flush patterns.
  localparam ctrl_t CTL_NONE   = '{en_f: 1'b0, en_d: 1'b0, en_e: 1'b0, en_m: 1'b0, en_w: 1'b0,
                                   flush_d: 1'b0, flush_e: 1'b0, flush_m: 1'b0};
  localparam ctrl_t CTL_RUN    = '{en_f: 1'b1, en_d: 1'b1, en_e: 1'b1, en_m: 1'b1, en_w: 1'b1,
                                   flush_d: 1'b0, flush_e: 1'b0, flush_m: 1'b0};
  localparam ctrl_t CTL_DIV    = '{en_f: 1'b0, en_d: 1'b0, en_e: 1'b0, en_m: 1'b1, en_w: 1'b1,
                                   flush_d: 1'b0, flush_e: 1'b0, flush_m: 1'b1};
  localparam ctrl_t CTL_LDUSE  = '{en_f: 1'b0, en_d: 1'b0, en_e: 1'b1, en_m: 1'b1, en_w: 1'b1,
                                   flush_d: 1'b0, flush_e: 1'b1, flush_m: 1'b0};
  localparam ctrl_t CTL_BRANCH = '{en_f: 1'b1, en_d: 1'b1, en_e: 1'b1, en_m: 1'b1, en_w: 1'b1,
                                   flush_d: 1'b1, flush_e: 1'b0, flush_m: 1'b0};

endpackage

// File: rtl/pipe_wait_ctrl_if.sv
// pipe_wait_ctrl_if: handshake/control bundle between the pipeline and
// its stall/flush sequencer.
//   slave  modport - sequencer side (takes requests, drives enables/flushes)
//   master modport - pipeline side
interface pipe_wait_ctrl_if;
  logic mem_req;
  logic mem_ready;
  logic div_start;
  logic div_ack;
  logic div_done;
  logic load_use;
  logic branch_taken;
  logic en_f;
  logic en_d;
  logic en_e;
  logic en_m;
  logic en_w;
  logic flush_d;
  logic flush_e;
  logic flush_m;
  logic busy;

  modport slave (
    input  mem_req, mem_ready, div_start, load_use, branch_taken,
    output div_ack, div_done, en_f, en_d, en_e, en_m, en_w,
           flush_d, flush_e, flush_m, busy
  );

  modport master (
    output mem_req, mem_ready, div_start, load_use, branch_taken,
    input  div_ack, div_done, en_f, en_d, en_e, en_m, en_w,
           flush_d, flush_e, flush_m, busy
  );
endinterface

// File: rtl/pipe_wait_ctrl_wait_down_counter.sv
// wait_down_counter: loadable down counter with zero flag.
//   clk, rst    - clock, asynchronous active-high reset (clears to 0)
//   i_load      - load i_load_val (has priority over decrement)
//   i_load_val  - value to load
//   i_dec       - decrement by one; holds at zero
//   o_cnt       - current count
//   o_zero      - count is zero
module wait_down_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_wait_ctrl.sv
// pipe_wait_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Arbitrates data-memory wait, multi-cycle divide, load-use hazard and taken
// branch, driving stage-register enables and bubble flushes combinationally
// from the registered state/counter and the current requests.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - pipe_wait_ctrl_if.slave (requests in; enables/flushes,
//              div_ack/div_done pulses and busy out)
//   stall_cycles, flush_count - only with PIPE_WAIT_PERF_EN defined:
//              saturating counts of cycles with en_f=0 / any flush active
// Parameters: DIV_CYCLES (2..255) divider occupancy, CNT_W counter width.
module pipe_wait_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_wait_ctrl_if.slave        bus
`ifdef PIPE_WAIT_PERF_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            flush_count
`endif
);

  state_t           r_state;
  state_t           w_next;
  ctrl_t            w_ctl;
  logic             w_ack;
  logic             w_done;
  logic             w_load;
  logic             w_dec;
  logic             w_zero;
  logic [CNT_W-1:0] w_cnt;

  // The ack cycle is the first of DIV_CYCLES occupied cycles and the done
  // cycle (count 0) is the last, so DIV_CYCLES-2 is loaded at ack.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  wait_down_counter #(.CNT_W(CNT_W)) u_div_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (DIV_LOAD),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ctl  = CTL_RUN;
    w_ack  = 1'b0;
    w_done = 1'b0;
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          w_next = MEM_WAIT;
          w_ctl  = CTL_NONE;
        end else if (bus.div_start) begin
          w_next = DIV_WAIT;
          w_ctl  = CTL_DIV;
          w_ack  = 1'b1;
          w_load = 1'b1;
        end else if (bus.load_use) begin
          w_ctl = CTL_LDUSE;
        end else if (bus.branch_taken) begin
          w_ctl = CTL_BRANCH;
        end
      end
      MEM_WAIT: begin
        // A dropped mem_req without mem_ready is an abort: release as if ready.
        if (bus.mem_ready || !bus.mem_req) w_next = RUN;
        else                               w_ctl  = CTL_NONE;
      end
      DIV_WAIT: begin
        if (w_zero) begin
          w_next = RUN;
          w_done = 1'b1;
        end else begin
          w_ctl = CTL_DIV;
          w_dec = 1'b1;
        end
      end
      default: w_next = RUN;
    endcase
    // Outputs are combinational, so reset must gate them directly.
    if (rst) begin
      w_ctl  = CTL_NONE;
      w_ack  = 1'b0;
      w_done = 1'b0;
    end
  end

  assign bus.en_f     = w_ctl.en_f;
  assign bus.en_d     = w_ctl.en_d;
  assign bus.en_e     = w_ctl.en_e;
  assign bus.en_m     = w_ctl.en_m;
  assign bus.en_w     = w_ctl.en_w;
  assign bus.flush_d  = w_ctl.flush_d;
  assign bus.flush_e  = w_ctl.flush_e;
  assign bus.flush_m  = w_ctl.flush_m;
  assign bus.div_ack  = w_ack;
  assign bus.div_done = w_done;
  assign bus.busy     = (r_state != RUN);

`ifdef PIPE_WAIT_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!w_ctl.en_f && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if ((w_ctl.flush_d || w_ctl.flush_e || w_ctl.flush_m) && (flush_count != '1))
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_wait_ctrl.sv
// Directed bench for pipe_wait_ctrl with DIV_CYCLES=4.
// Observed vector: {busy, div_ack, div_done, en_f,en_d,en_e,en_m,en_w,
//                   flush_d,flush_e,flush_m}
module tb_pipe_wait_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pipe_wait_ctrl_if bus ();

`ifdef PIPE_WAIT_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  pipe_wait_ctrl #(.DIV_CYCLES(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PIPE_WAIT_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  localparam logic [10:0] V_ZERO   = 11'b000_00000_000;
  localparam logic [10:0] V_IDLE   = 11'b000_11111_000;
  localparam logic [10:0] V_MWAIT  = 11'b100_00000_000;
  localparam logic [10:0] V_MREL   = 11'b100_11111_000;
  localparam logic [10:0] V_DACK   = 11'b010_00011_001;
  localparam logic [10:0] V_DWAIT  = 11'b100_00011_001;
  localparam logic [10:0] V_DDONE  = 11'b101_11111_000;
  localparam logic [10:0] V_LDUSE  = 11'b000_00111_010;
  localparam logic [10:0] V_BRANCH = 11'b000_11111_100;

  function automatic logic [10:0] obs();
    return {bus.busy, bus.div_ack, bus.div_done,
            bus.en_f, bus.en_d, bus.en_e, bus.en_m, bus.en_w,
            bus.flush_d, bus.flush_e, bus.flush_m};
  endfunction

  task automatic chk(input string tag, input logic [10:0] exp);
    logic [10:0] o;
    #1;
    o = obs();
    n_vec++;
    assert (o === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mreq, input logic mrdy, input logic dstart,
                       input logic luse, input logic br);
    bus.mem_req      = mreq;
    bus.mem_ready    = mrdy;
    bus.div_start    = dstart;
    bus.load_use     = luse;
    bus.branch_taken = br;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    #2;
    chk("reset", V_ZERO);
    tick();
    chk("reset_hold", V_ZERO);
    rst = 1'b0;
    chk("idle_after_reset", V_IDLE);

    // Memory wait: 3 stalled cycles, release on the 4th.
    tick(); drive(1, 0, 0, 0, 0);
    chk("mem_enter", V_ZERO);
    tick(); chk("mem_wait1", V_MWAIT);
    tick(); chk("mem_wait2", V_MWAIT);
    tick(); drive(1, 1, 0, 0, 0);
    chk("mem_release", V_MREL);
    tick(); drive(0, 0, 0, 0, 0);
    chk("mem_idle", V_IDLE);

    // Divide, DIV_CYCLES=4: ack T0, wait T1..T2, done T3.
    tick(); drive(0, 0, 1, 0, 0);
    chk("div_ack", V_DACK);
    tick(); drive(0, 0, 0, 0, 0);
    chk("div_t1", V_DWAIT);
    tick(); chk("div_t2", V_DWAIT);
    tick(); chk("div_done", V_DDONE);
    tick(); chk("div_idle", V_IDLE);

    // Priority: memory stall beats divide and load-use.
    tick(); drive(1, 0, 1, 1, 0);
    chk("prio_enter", V_ZERO);
    tick(); chk("prio_wait", V_MWAIT);
    tick(); drive(1, 1, 1, 1, 0);
    chk("prio_release", V_MREL);
    tick(); drive(0, 0, 1, 0, 0);
    chk("prio_div_ack", V_DACK);
    tick(); drive(0, 0, 0, 0, 0);
    chk("prio_div_t1", V_DWAIT);
    tick(); chk("prio_div_t2", V_DWAIT);
    tick(); chk("prio_div_done", V_DDONE);

    // Single-cycle load-use.
    tick(); drive(0, 0, 0, 1, 0);
    chk("load_use", V_LDUSE);
    tick(); drive(0, 0, 0, 0, 0);
    chk("load_use_after", V_IDLE);

    // Load-use outranks branch; mem_req with mem_ready same cycle is no stall.
    tick(); drive(1, 1, 0, 1, 1);
    chk("lduse_over_branch", V_LDUSE);
    tick(); drive(1, 1, 0, 0, 0);
    chk("mem_ready_same_cycle", V_IDLE);

    // Branch held through a 2-cycle MEM_WAIT.
    tick(); drive(1, 0, 0, 0, 1);
    chk("br_stall_enter", V_ZERO);
    tick(); chk("br_stall_wait", V_MWAIT);
    tick(); drive(1, 1, 0, 0, 1);
    chk("br_stall_release", V_MREL);
    tick(); drive(0, 0, 0, 0, 1);
    chk("br_honoured", V_BRANCH);
    tick(); drive(0, 0, 0, 0, 0);
    chk("br_idle", V_IDLE);

    // Memory abort: mem_req drops without mem_ready.
    tick(); drive(1, 0, 0, 0, 0);
    chk("abort_enter", V_ZERO);
    tick(); drive(0, 0, 0, 0, 0);
    chk("abort_release", V_MREL);
    tick(); chk("abort_idle", V_IDLE);

    // Stray mem stall during DIV_WAIT is ignored.
    tick(); drive(0, 0, 1, 0, 0);
    chk("div2_ack", V_DACK);
    tick(); drive(1, 0, 0, 0, 1);
    chk("div2_ignore_mem", V_DWAIT);
    tick(); drive(0, 0, 0, 0, 0);
    chk("div2_t2", V_DWAIT);
    tick(); chk("div2_done", V_DDONE);

    // Reset in the middle of DIV_WAIT.
    tick(); drive(0, 0, 1, 0, 0);
    chk("div3_ack", V_DACK);
    tick(); drive(0, 0, 0, 0, 0);
    chk("div3_t1", V_DWAIT);
    rst = 1'b1;
    chk("midreset", V_ZERO);
    tick(); chk("midreset_hold", V_ZERO);
    rst = 1'b0;
    chk("midreset_release", V_IDLE);
    tick(); chk("post_reset_1", V_IDLE);
    tick(); chk("post_reset_2", V_IDLE);
    tick(); chk("post_reset_3", V_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
